// File: rtl/modn_counter_if.sv
// Signal bundle for the modulo-N counter: control inputs, load data and count/status outputs.
`timescale 1ns/1ps
interface modn_counter_if #(
  parameter int WIDTH = 4
) ();
  logic             en;
  logic             up_dn;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] Q;
  logic             tc;
  logic             wrap;
  logic             load_err;

  modport master (
    output en, up_dn, clr, load, load_val,
    input  Q, tc, wrap, load_err
  );

  modport slave (
    input  en, up_dn, clr, load, load_val,
    output Q, tc, wrap, load_err
  );
endinterface

// File: rtl/modn_counter.sv
// Parametrised falling-edge modulo-N up/down counter with clear, parallel load,
// terminal-count and registered wrap / load-error pulses for cascading.
`timescale 1ns/1ps
module modn_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 13
) (
  input  logic          clk,
  input  logic          mrst,
  modn_counter_if.slave bus
);

  generate
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
      $error("modn_counter: MODULUS %0d outside legal range 2..2**WIDTH", MODULUS);
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

  // Wrapping step in WIDTH bits; at MODULUS == 2**WIDTH the explicit wrap
  // and the natural overflow agree.
  function automatic logic [WIDTH-1:0] mod_inc(input logic [WIDTH-1:0] v);
    return (v == MAX_Q) ? '0 : v + ONE;
  endfunction

  function automatic logic [WIDTH-1:0] mod_dec(input logic [WIDTH-1:0] v);
    return (v == '0) ? MAX_Q : v - ONE;
  endfunction

  logic [WIDTH-1:0] q_p0;
  logic             wrap_p0;
  logic             load_err_p0;

  logic [WIDTH-1:0] q_nxt;
  logic             wrap_nxt;
  logic             load_err_nxt;
  logic             load_ok;

  assign load_ok = ({1'b0, bus.load_val} < MOD_EXT);

  always_comb begin
    q_nxt        = q_p0;
    wrap_nxt     = 1'b0;
    load_err_nxt = 1'b0;
    if (bus.clr) begin
      q_nxt = '0;
    end else if (bus.load) begin
      if (load_ok) begin
        q_nxt = bus.load_val;
      end else begin
        q_nxt        = '0;
        load_err_nxt = 1'b1;
      end
    end else if (bus.en) begin
      if (bus.up_dn) begin
        q_nxt    = mod_inc(q_p0);
        wrap_nxt = (q_p0 == MAX_Q);
      end else begin
        q_nxt    = mod_dec(q_p0);
        wrap_nxt = (q_p0 == '0);
      end
    end
  end

  // Stage p0: count and status registers, updated on the falling edge
  always_ff @(negedge clk or negedge mrst) begin
    if (!mrst) begin
      q_p0        <= '0;
      wrap_p0     <= 1'b0;
      load_err_p0 <= 1'b0;
    end else begin
      q_p0        <= q_nxt;
      wrap_p0     <= wrap_nxt;
      load_err_p0 <= load_err_nxt;
    end
  end

  assign bus.Q        = q_p0;
  assign bus.wrap     = wrap_p0;
  assign bus.load_err = load_err_p0;
  assign bus.tc       = bus.en & (bus.up_dn ? (q_p0 == MAX_Q) : (q_p0 == '0));

endmodule

// File: tb/tb_modn_counter.sv
// Bench for modn_counter: mod-13 (4-bit) and full-range mod-8 (3-bit) instances
// checked every cycle against an arithmetic model plus directed literal checks.
`timescale 1ns/1ps
module tb_modn_counter;

  logic clk;
  logic mrst;
  int   checks   = 0;
  int   failures = 0;
  bit   run_cmp  = 1'b0;

  modn_counter_if #(.WIDTH(4)) a_if ();
  modn_counter_if #(.WIDTH(3)) b_if ();

  modn_counter #(.WIDTH(4), .MODULUS(13)) dut_a (.clk(clk), .mrst(mrst), .bus(a_if.slave));
  modn_counter #(.WIDTH(3), .MODULUS(8))  dut_b (.clk(clk), .mrst(mrst), .bus(b_if.slave));

  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain modular arithmetic on integers
  function automatic void model_step(input int m, input logic clr, input logic load,
                                     input logic en, input logic up, input int lv,
                                     inout int q, output int w, output int e);
    w = 0;
    e = 0;
    if (clr) q = 0;
    else if (load) begin
      if (lv < m) q = lv;
      else begin q = 0; e = 1; end
    end else if (en) begin
      if (up) begin w = (q == m - 1); q = (q + 1) % m; end
      else    begin w = (q == 0);     q = (q + m - 1) % m; end
    end
  endfunction

  function automatic int model_tc(input int m, input logic en, input logic up, input int q);
    if (!en) return 0;
    return up ? int'(q == m - 1) : int'(q == 0);
  endfunction

  int mq_a = 0, mw_a = 0, me_a = 0;
  int mq_b = 0, mw_b = 0, me_b = 0;

  always @(negedge clk or negedge mrst) begin
    if (!mrst) begin
      mq_a = 0; mw_a = 0; me_a = 0;
      mq_b = 0; mw_b = 0; me_b = 0;
    end else begin
      model_step(13, a_if.clr, a_if.load, a_if.en, a_if.up_dn, int'(a_if.load_val), mq_a, mw_a, me_a);
      model_step(8,  b_if.clr, b_if.load, b_if.en, b_if.up_dn, int'(b_if.load_val), mq_b, mw_b, me_b);
    end
  end

  always @(posedge clk) begin
    if (run_cmp) begin
      chk("a_Q_model",    int'(a_if.Q),        mq_a);
      chk("a_wrap_model", int'(a_if.wrap),     mw_a);
      chk("a_err_model",  int'(a_if.load_err), me_a);
      chk("a_tc_model",   int'(a_if.tc),       model_tc(13, a_if.en, a_if.up_dn, mq_a));
      chk("b_Q_model",    int'(b_if.Q),        mq_b);
      chk("b_wrap_model", int'(b_if.wrap),     mw_b);
      chk("b_err_model",  int'(b_if.load_err), me_b);
      chk("b_tc_model",   int'(b_if.tc),       model_tc(8, b_if.en, b_if.up_dn, mq_b));
    end
  end

  // One falling edge, then park just after the following rising edge
  task automatic tick();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic en, input logic up, input logic clr,
                       input logic load, input logic [3:0] lv);
    a_if.en = en; a_if.up_dn = up; a_if.clr = clr; a_if.load = load; a_if.load_val = lv;
  endtask

  task automatic set_b(input logic en, input logic up, input logic clr,
                       input logic load, input logic [2:0] lv);
    b_if.en = en; b_if.up_dn = up; b_if.clr = clr; b_if.load = load; b_if.load_val = lv;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_d[4];
    int exp_w[4];
    exp_d = '{1, 0, 12, 11};
    exp_w = '{0, 0, 1, 0};

    mrst = 1'b0;
    set_a(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    set_b(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
    #12;
    chk("rst_Q", int'(a_if.Q), 0);
    chk("rst_wrap", int'(a_if.wrap), 0);
    chk("rst_err", int'(a_if.load_err), 0);
    chk("rst_tc_en0", int'(a_if.tc), 0);
    a_if.en = 1'b1;
    #1;
    chk("rst_tc_down_en1", int'(a_if.tc), 1);
    run_cmp = 1'b1;
    mrst = 1'b1;

    // Up count through the wrap
    set_a(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    for (int i = 1; i <= 14; i++) begin
      tick();
      chk("up_Q", int'(a_if.Q), i % 13);
      chk("up_tc", int'(a_if.tc), int'((i % 13) == 12));
      chk("up_wrap", int'(a_if.wrap), int'(i == 13));
    end

    // Down count and direction change
    set_a(1'b1, 1'b0, 1'b0, 1'b1, 4'd2);
    tick();
    chk("dn_load2", int'(a_if.Q), 2);
    a_if.load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("dn_Q", int'(a_if.Q), exp_d[i]);
      chk("dn_wrap", int'(a_if.wrap), exp_w[i]);
    end
    a_if.up_dn = 1'b1;
    #1;
    chk("dir_tc_before", int'(a_if.tc), 0);
    tick();
    chk("dir_Q", int'(a_if.Q), 12);
    chk("dir_tc", int'(a_if.tc), 1);

    // Load, range check, priority
    set_a(1'b0, 1'b1, 1'b0, 1'b1, 4'd9);
    tick();
    chk("ld9_Q", int'(a_if.Q), 9);
    chk("ld9_err", int'(a_if.load_err), 0);
    a_if.load_val = 4'd14;
    tick();
    chk("ld14_Q", int'(a_if.Q), 0);
    chk("ld14_err", int'(a_if.load_err), 1);
    a_if.load = 1'b0;
    tick();
    chk("ld14_err_clear", int'(a_if.load_err), 0);
    set_a(1'b0, 1'b1, 1'b0, 1'b1, 4'd12);
    tick();
    chk("ld12_Q", int'(a_if.Q), 12);
    set_a(1'b1, 1'b1, 1'b0, 1'b1, 4'd5);
    tick();
    chk("ld_over_en_Q", int'(a_if.Q), 5);
    chk("ld_over_en_wrap", int'(a_if.wrap), 0);
    set_a(1'b1, 1'b1, 1'b1, 1'b1, 4'd3);
    tick();
    chk("clr_over_ld_Q", int'(a_if.Q), 0);

    // Asynchronous reset mid-count
    set_a(1'b0, 1'b1, 1'b0, 1'b1, 4'd7);
    tick();
    chk("ar_pre_Q", int'(a_if.Q), 7);
    set_a(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
    #2;
    mrst = 1'b0;
    #1;
    chk("ar_async_Q", int'(a_if.Q), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ar_hold_Q", int'(a_if.Q), 0);
    end
    mrst = 1'b1;
    tick();
    chk("ar_resume_Q", int'(a_if.Q), 1);

    // Enable hold
    set_a(1'b0, 1'b1, 1'b0, 1'b1, 4'd4);
    tick();
    a_if.load = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_Q", int'(a_if.Q), 4);
      chk("hold_tc", int'(a_if.tc), 0);
      chk("hold_wrap", int'(a_if.wrap), 0);
    end

    // Full-range modulus on the 3-bit instance
    set_b(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
    tick();
    chk("b_clr_Q", int'(b_if.Q), 0);
    set_b(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("b_up_Q", int'(b_if.Q), i % 8);
      chk("b_up_wrap", int'(b_if.wrap), int'(i == 8));
    end
    b_if.up_dn = 1'b0;
    tick();
    chk("b_dn_Q", int'(b_if.Q), 7);
    chk("b_dn_wrap", int'(b_if.wrap), 1);

    // Randomised traffic on both instances
    for (int i = 0; i < 1000; i++) begin
      set_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 7) == 0), 4'($urandom_range(0, 15)));
      set_b(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 7) == 0), 3'($urandom_range(0, 7)));
      tick();
      chk("a_range", int'(a_if.Q <= 4'd12), 1);
    end

    run_cmp = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
